gmii_rx_preamble_strip: RTL and testbench

Parametrised GMII receive front end. Checks preamble length and SFD, strips them, and emits the frame payload as a byte stream with start-of-frame pulse, tlast and error flag. It sits between the GMII receive pins domain (mac_gmii_rx_clk) and the MAC RX parser. It generalises the fixed 7-byte preamble check to a configurable length window and adds payload framing and error tagging.

---
 rtl/gmii_rx_preamble_strip_if.sv | 47 ++++
 rtl/gmii_rx_preamble_strip.sv | 202 ++++++++++++++++++++
 tb/tb_gmii_rx_preamble_strip.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_preamble_strip_if.sv
// rtl/gmii_rx_preamble_strip_if.sv - GMII receive pins and payload stream bundle; stats signals only with GMII_RX_PREAMBLE_STATS_EN
interface gmii_rx_preamble_strip_if
`ifdef GMII_RX_PREAMBLE_STATS_EN
  #(parameter int STAT_W = 16)
`endif
  ;
  logic [7:0] mac_gmii_rxd;
  logic       mac_gmii_rx_dv;
  logic       mac_gmii_rx_er;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       preamble_sfd_valid;
  logic [3:0] preamble_len;
`ifdef GMII_RX_PREAMBLE_STATS_EN
  logic [STAT_W-1:0] stat_good_sfd;
  logic [STAT_W-1:0] stat_bad_preamble;
  logic [STAT_W-1:0] stat_rx_err_frames;

  modport slave (
    input  mac_gmii_rxd, mac_gmii_rx_dv, mac_gmii_rx_er,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output preamble_sfd_valid, preamble_len,
    output stat_good_sfd, stat_bad_preamble, stat_rx_err_frames
  );

  modport master (
    output mac_gmii_rxd, mac_gmii_rx_dv, mac_gmii_rx_er,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  preamble_sfd_valid, preamble_len,
    input  stat_good_sfd, stat_bad_preamble, stat_rx_err_frames
  );
`else
  modport slave (
    input  mac_gmii_rxd, mac_gmii_rx_dv, mac_gmii_rx_er,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output preamble_sfd_valid, preamble_len
  );

  modport master (
    output mac_gmii_rxd, mac_gmii_rx_dv, mac_gmii_rx_er,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  preamble_sfd_valid, preamble_len
  );
`endif
endinterface

// File: rtl/gmii_rx_preamble_strip.sv
// rtl/gmii_rx_preamble_strip.sv - GMII RX preamble/SFD check and strip to a framed byte stream; optional counters via GMII_RX_PREAMBLE_STATS_EN
module gmii_rx_preamble_strip #(
  parameter int MIN_PREAMBLE_LEN = 7,
  parameter int MAX_PREAMBLE_LEN = 15,
  parameter int STAT_W           = 16
) (
  input logic                     mac_gmii_rx_clk,
  input logic                     mac_gmii_rx_rst,
  gmii_rx_preamble_strip_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [3:0] MIN_LEN  = 4'(MIN_PREAMBLE_LEN);
  localparam logic [3:0] MAX_LEN  = 4'(MAX_PREAMBLE_LEN);
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] hold_data, hold_data_nxt;
  logic       hold_full, hold_full_nxt;
  logic       err_flag, err_flag_nxt;
  logic [7:0] tdata, tdata_nxt;
  logic       tvalid, tvalid_nxt;
  logic       tlast, tlast_nxt;
  logic       tuser, tuser_nxt;
  logic       sfd_valid, sfd_valid_nxt;
  logic [3:0] plen, plen_nxt;
  logic       bad_evt;

  logic [7:0] rxd;
  logic       rx_dv;
  logic       rx_er;

  assign rxd   = bus.mac_gmii_rxd;
  assign rx_dv = bus.mac_gmii_rx_dv;
  assign rx_er = bus.mac_gmii_rx_er;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hold_data_nxt = hold_data;
    hold_full_nxt = hold_full;
    err_flag_nxt  = err_flag;
    tdata_nxt     = 8'd0;
    tvalid_nxt    = 1'b0;
    tlast_nxt     = 1'b0;
    tuser_nxt     = 1'b0;
    sfd_valid_nxt = 1'b0;
    plen_nxt      = plen;
    bad_evt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_dv) begin
          if (!rx_er && rxd == PRE_BYTE) begin
            state_nxt = S_PREAMBLE;
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!rx_dv) begin
          state_nxt = S_IDLE;
        end else if (rx_er) begin
          state_nxt = S_DROP;
          bad_evt   = 1'b1;
        end else if (rxd == PRE_BYTE) begin
          // Comparing before incrementing keeps cnt from ever wrapping past 15.
          if (cnt >= MAX_LEN) begin
            state_nxt = S_DROP;
            bad_evt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end else if (rxd == SFD_BYTE && cnt >= MIN_LEN) begin
          state_nxt     = S_PAYLOAD;
          sfd_valid_nxt = 1'b1;
          plen_nxt      = cnt;
          err_flag_nxt  = 1'b0;
          hold_full_nxt = 1'b0;
        end else begin
          state_nxt = S_DROP;
          bad_evt   = 1'b1;
        end
      end

      S_PAYLOAD: begin
        // One byte of lookahead so tlast can ride on the final byte when dv falls.
        if (rx_dv) begin
          if (hold_full) begin
            tvalid_nxt = 1'b1;
            tdata_nxt  = hold_data;
          end
          hold_data_nxt = rxd;
          hold_full_nxt = 1'b1;
          if (rx_er) begin
            err_flag_nxt = 1'b1;
          end
        end else begin
          if (hold_full) begin
            tvalid_nxt = 1'b1;
            tdata_nxt  = hold_data;
            tlast_nxt  = 1'b1;
            tuser_nxt  = err_flag;
          end
          hold_full_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end

      S_DROP: begin
        if (!rx_dv) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_DROP;
      end
    endcase
  end

  always_ff @(posedge mac_gmii_rx_clk) begin
    if (mac_gmii_rx_rst) begin
      state     <= S_DROP;
      cnt       <= 4'd0;
      hold_data <= 8'd0;
      hold_full <= 1'b0;
      err_flag  <= 1'b0;
      tdata     <= 8'd0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      tuser     <= 1'b0;
      sfd_valid <= 1'b0;
      plen      <= 4'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_data <= hold_data_nxt;
      hold_full <= hold_full_nxt;
      err_flag  <= err_flag_nxt;
      tdata     <= tdata_nxt;
      tvalid    <= tvalid_nxt;
      tlast     <= tlast_nxt;
      tuser     <= tuser_nxt;
      sfd_valid <= sfd_valid_nxt;
      plen      <= plen_nxt;
    end
  end

  assign bus.m_axis_tdata       = tdata;
  assign bus.m_axis_tvalid      = tvalid;
  assign bus.m_axis_tlast       = tlast;
  assign bus.m_axis_tuser       = tuser;
  assign bus.preamble_sfd_valid = sfd_valid;
  assign bus.preamble_len       = plen;

`ifdef GMII_RX_PREAMBLE_STATS_EN
  logic [STAT_W-1:0] good_cnt;
  logic [STAT_W-1:0] bad_cnt;
  logic [STAT_W-1:0] errf_cnt;
  logic              errf_evt;

  assign errf_evt = tvalid_nxt & tlast_nxt & tuser_nxt;

  // Counters saturate at all-ones so software can tell overflow from a small count.
  always_ff @(posedge mac_gmii_rx_clk) begin
    if (mac_gmii_rx_rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      errf_cnt <= '0;
    end else begin
      assert (!(sfd_valid_nxt && bad_evt));
      if (sfd_valid_nxt && !(&good_cnt)) begin
        good_cnt <= good_cnt + STAT_W'(1);
      end
      if (bad_evt && !(&bad_cnt)) begin
        bad_cnt <= bad_cnt + STAT_W'(1);
      end
      if (errf_evt && !(&errf_cnt)) begin
        errf_cnt <= errf_cnt + STAT_W'(1);
      end
    end
  end

  assign bus.stat_good_sfd      = good_cnt;
  assign bus.stat_bad_preamble  = bad_cnt;
  assign bus.stat_rx_err_frames = errf_cnt;
`else
  logic unused_stats;
  assign unused_stats = bad_evt ^ (STAT_W > 0);
`endif
endmodule

// File: tb/tb_gmii_rx_preamble_strip.sv
// tb/tb_gmii_rx_preamble_strip.sv - directed and random frames checked against a frame-level reference model
module tb_gmii_rx_preamble_strip;
  localparam int MINL = 7;
  localparam int MAXL = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gmii_rx_preamble_strip_if bus ();

  gmii_rx_preamble_strip #(
    .MIN_PREAMBLE_LEN(MINL),
    .MAX_PREAMBLE_LEN(MAXL),
    .STAT_W(16)
  ) dut (
    .mac_gmii_rx_clk(clk),
    .mac_gmii_rx_rst(rst),
    .bus(bus)
  );

  typedef struct { logic dv; logic er; logic rs; logic [7:0] d; } cyc_t;
  typedef struct { logic [7:0] d; logic last; logic user; } beat_t;

  cyc_t  stim[$];
  beat_t got[$];
  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int got_pulses = 0;
  int exp_pulses = 0;
  int idle_junk = 0;
  logic [3:0] m_plen = 4'd0;
  int m_good = 0;
  int m_bad = 0;
  int m_errf = 0;
  bit m_block = 1'b1;

  always @(negedge clk) begin
    if (bus.m_axis_tvalid === 1'b1)
      got.push_back('{d: bus.m_axis_tdata, last: bus.m_axis_tlast, user: bus.m_axis_tuser});
    else if ({bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser} !== 10'd0)
      idle_junk++;
    if (bus.preamble_sfd_valid === 1'b1)
      got_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame-level rules: one dv-high run is one frame attempt.
  function automatic void eval_run(input cyc_t run[$], input bit trunc);
    int n;
    int cnt;
    int i;
    int npay;
    logic any_er;
    n = run.size();
    if (n == 0) return;
    if (run[0].er || run[0].d != 8'h55) return;
    cnt = 1;
    for (i = 1; i < n; i++) begin
      if (run[i].er) begin m_bad++; return; end
      if (run[i].d == 8'h55) begin
        if (cnt + 1 > MAXL) begin m_bad++; return; end
        cnt++;
      end else if (run[i].d == 8'hD5 && cnt >= MINL) begin
        break;
      end else begin
        m_bad++;
        return;
      end
    end
    if (i >= n) return;
    exp_pulses++;
    m_good++;
    m_plen = 4'(cnt);
    npay = n - 1 - i;
    any_er = 1'b0;
    for (int j = 0; j < npay; j++) any_er |= run[i + 1 + j].er;
    for (int j = 0; j < npay; j++) begin
      if (j != npay - 1)
        exp_q.push_back('{d: run[i + 1 + j].d, last: 1'b0, user: 1'b0});
      else if (!trunc) begin
        exp_q.push_back('{d: run[i + 1 + j].d, last: 1'b1, user: any_er});
        if (any_er) m_errf++;
      end
    end
  endfunction

  function automatic void model();
    cyc_t run[$];
    foreach (stim[k]) begin
      if (stim[k].rs) begin
        eval_run(run, 1'b1);
        run.delete();
        m_plen = 4'd0; m_good = 0; m_bad = 0; m_errf = 0;
        m_block = 1'b1;
      end else if (stim[k].dv) begin
        if (!m_block) run.push_back(stim[k]);
      end else begin
        eval_run(run, 1'b0);
        run.delete();
        m_block = 1'b0;
      end
    end
    eval_run(run, 1'b1);
  endfunction

  task automatic add_byte(input logic [7:0] d, input logic er);
    stim.push_back('{dv: 1'b1, er: er, rs: 1'b0, d: d});
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) stim.push_back('{dv: 1'b0, er: 1'b0, rs: 1'b0, d: 8'($urandom)});
  endtask

  task automatic add_pre(input int n);
    for (int k = 0; k < n; k++) add_byte(8'h55, 1'b0);
  endtask

  task automatic add_good(input int npay, input int er_idx);
    add_pre(7);
    add_byte(8'hD5, 1'b0);
    for (int k = 0; k < npay; k++) add_byte(8'(k + 1), k == er_idx);
  endtask

  task automatic add_rand_frame();
    int npre;
    int kind;
    int npay;
    npre = $urandom_range(1, 17);
    kind = $urandom_range(0, 19);
    npay = $urandom_range(0, 12);
    if (kind == 0) add_byte(8'($urandom), 1'b0);
    for (int k = 0; k < npre; k++) add_byte(8'h55, $urandom_range(0, 39) == 0);
    add_byte(kind < 17 ? 8'hD5 : 8'($urandom), 1'b0);
    for (int k = 0; k < npay; k++) add_byte(8'($urandom), $urandom_range(0, 19) == 0);
    add_idle($urandom_range(1, 3));
  endtask

  task automatic play(input string tag);
    int n;
    add_idle(3);
    got.delete();
    exp_q.delete();
    got_pulses = 0;
    exp_pulses = 0;
    idle_junk = 0;
    model();
    foreach (stim[k]) begin
      @(negedge clk);
      rst = stim[k].rs;
      bus.mac_gmii_rx_dv = stim[k].dv;
      bus.mac_gmii_rx_er = stim[k].er;
      bus.mac_gmii_rxd = stim[k].d;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.mac_gmii_rx_dv = 1'b0;
    bus.mac_gmii_rx_er = 1'b0;
    #1;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    check({tag, ".nbeats"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++)
      check($sformatf("%s.beat%0d", tag, i),
            {22'd0, got[i].d, got[i].last, got[i].user},
            {22'd0, exp_q[i].d, exp_q[i].last, exp_q[i].user});
    check({tag, ".pulses"}, 32'(got_pulses), 32'(exp_pulses));
    check({tag, ".plen"}, {28'd0, bus.preamble_len}, {28'd0, m_plen});
    check({tag, ".idle_zero"}, 32'(idle_junk), 32'd0);
`ifdef GMII_RX_PREAMBLE_STATS_EN
    check({tag, ".stat_good"}, 32'(bus.stat_good_sfd), 32'(m_good));
    check({tag, ".stat_bad"}, 32'(bus.stat_bad_preamble), 32'(m_bad));
    check({tag, ".stat_errf"}, 32'(bus.stat_rx_err_frames), 32'(m_errf));
`endif
    stim.delete();
  endtask

  initial begin
    bus.mac_gmii_rxd = 8'h55;
    bus.mac_gmii_rx_dv = 1'b1;
    bus.mac_gmii_rx_er = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
    check("rst.tdata", {24'd0, bus.m_axis_tdata}, 32'd0);
    check("rst.tlast", {31'd0, bus.m_axis_tlast}, 32'd0);
    check("rst.tuser", {31'd0, bus.m_axis_tuser}, 32'd0);
    check("rst.sfd", {31'd0, bus.preamble_sfd_valid}, 32'd0);
    check("rst.plen", {28'd0, bus.preamble_len}, 32'd0);
`ifdef GMII_RX_PREAMBLE_STATS_EN
    check("rst.stat_good", 32'(bus.stat_good_sfd), 32'd0);
    check("rst.stat_bad", 32'(bus.stat_bad_preamble), 32'd0);
    check("rst.stat_errf", 32'(bus.stat_rx_err_frames), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    bus.mac_gmii_rx_dv = 1'b0;
    @(negedge clk);
    m_block = 1'b0;

    add_good(4, -1);
    play("t1_basic");

    add_pre(5); add_byte(8'hD5, 1'b0);
    add_byte(8'h11, 1'b0); add_byte(8'h22, 1'b0); add_byte(8'h33, 1'b0);
    add_idle(1);
    play("t2_short_pre");

    add_good(6, 2);
    play("t3_rx_er");

    add_pre(16); add_byte(8'hD5, 1'b0);
    add_idle(1);
    add_good(5, -1);
    play("t4_long_pre");

    add_good(0, -1);
    play("t5_empty");

    add_pre(15); add_byte(8'hD5, 1'b0); add_byte(8'hA5, 1'b0);
    add_idle(1);
    add_good(3, -1);
    add_good(2, -1);
    play("t_max_b2b");

    add_good(2, -1);
    stim.push_back('{dv: 1'b1, er: 1'b0, rs: 1'b1, d: 8'h03});
    for (int k = 4; k <= 8; k++) add_byte(8'(k), 1'b0);
    add_idle(1);
    add_good(3, -1);
    play("t6_reset");

    for (int r = 0; r < 25; r++) begin
      for (int f = 0; f < 4; f++) add_rand_frame();
      play($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
